// File: rtl/oam_dma_arbiter_if.sv
// oam_dma_arbiter_if: CPU-side and memory-side bus signals of the OAM DMA arbiter
interface oam_dma_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0]      cpu_din;
    logic                  cpu_we;
    logic [WIDTH-1:0]      cpu_dout;
    logic                  cpu_rdy;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_din;
    logic                  mem_we;
    logic [WIDTH-1:0]      mem_dout;
    logic                  dma_busy;
    modport slave (
        input  cpu_addr, cpu_din, cpu_we, mem_dout,
        output cpu_dout, cpu_rdy, mem_addr, mem_din, mem_we, dma_busy
    );
    modport master (
        output cpu_addr, cpu_din, cpu_we, mem_dout,
        input  cpu_dout, cpu_rdy, mem_addr, mem_din, mem_we, dma_busy
    );
endinterface

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: stalls the CPU and copies one 256-byte page to OAM_DATA_ADDR.
// Define OAM_DMA_ALIGN_EN to insert an ALIGN cycle when HALT falls on odd parity.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
module oam_dma_arbiter #(
    parameter int WIDTH = `REG_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004
) (
    input logic clk,
    input logic reset,
    oam_dma_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [WIDTH-1:0] latch_q, latch_d;
    logic parity_q, parity_d;
    logic align_now;
`ifdef OAM_DMA_ALIGN_EN
    assign align_now = parity_q;
`else
    assign align_now = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        page_d = page_q;
        idx_d = idx_q;
        latch_d = latch_q;
        parity_d = ~parity_q;
        bus.cpu_dout = '0;
        bus.cpu_rdy = 1'b0;
        bus.dma_busy = 1'b1;
        bus.mem_addr = ADDR_WIDTH'({page_q, idx_q});
        bus.mem_din = latch_q;
        bus.mem_we = 1'b0;
        case (state_q)
            IDLE: begin
                bus.mem_addr = bus.cpu_addr;
                bus.mem_din = bus.cpu_din;
                bus.mem_we = bus.cpu_we;
                bus.cpu_dout = bus.mem_dout;
                bus.cpu_rdy = 1'b1;
                bus.dma_busy = 1'b0;
                if (bus.cpu_we && bus.cpu_addr == DMA_REG_ADDR) begin
                    page_d = bus.cpu_din;
                    idx_d = 8'd0;
                    state_d = HALT;
                end
            end
            HALT: state_d = align_now ? ALIGN : READ;
            ALIGN: state_d = READ;
            READ: begin
                latch_d = bus.mem_dout;
                state_d = WRITE;
            end
            WRITE: begin
                bus.mem_addr = OAM_DATA_ADDR;
                bus.mem_we = 1'b1;
                idx_d = idx_q + 8'd1;
                state_d = idx_q == 8'hFF ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            page_q <= '0;
            idx_q <= '0;
            latch_q <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q <= page_d;
            idx_q <= idx_d;
            latch_q <= latch_d;
            parity_q <= parity_d;
        end
    end
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: directed stimulus with a cycle-offset model of the DMA transfer
module tb_oam_dma_arbiter;
`ifdef OAM_DMA_ALIGN_EN
    localparam int ALIGN_EN = 1;
`else
    localparam int ALIGN_EN = 0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    oam_dma_arbiter_if #(.WIDTH(8), .ADDR_WIDTH(16)) bus ();
    oam_dma_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
    logic [7:0] mem [0:65535];
    assign bus.mem_dout = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_din;
    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 20) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // model: k = cycles since the trigger edge, al = 1 when an ALIGN cycle is due
    bit armed = 0, in_dma = 0, par = 0;
    int k = 0, al = 0;
    logic [7:0] pg = 8'h00;
    always @(posedge clk) begin
        if (reset) begin
            armed <= 1;
            in_dma <= 0;
            par <= 0;
        end else begin
            par <= ~par;
            if (!in_dma) begin
                if (armed && bus.cpu_we === 1'b1 && bus.cpu_addr == 16'h4014) begin
                    in_dma <= 1;
                    k <= 0;
                    pg <= bus.cpu_din;
                    al <= (ALIGN_EN == 1 && !par) ? 1 : 0;
                end
            end else if (k + 1 == 513 + al) in_dma <= 0;
            else k <= k + 1;
        end
    end
    logic [7:0] wq [$];
    int oob = 0;
    always @(negedge clk) begin
        if (armed) begin
            if (!in_dma) begin
                chk("idle_rdy", bus.cpu_rdy, 1);
                chk("idle_busy", bus.dma_busy, 0);
                chk("idle_addr", bus.mem_addr, bus.cpu_addr);
                chk("idle_din", bus.mem_din, bus.cpu_din);
                chk("idle_we", bus.mem_we, bus.cpu_we);
                chk("idle_dout", bus.cpu_dout, mem[bus.cpu_addr]);
            end else begin
                int o;
                logic [15:0] src;
                o = k - 1 - al;
                src = {pg, 8'(o / 2)};
                chk("dma_rdy", bus.cpu_rdy, 0);
                chk("dma_busy", bus.dma_busy, 1);
                chk("dma_dout", bus.cpu_dout, 0);
                if (o < 0) chk("halt_we", bus.mem_we, 0);
                else if (o % 2 == 0) begin
                    chk("read_addr", bus.mem_addr, src);
                    chk("read_we", bus.mem_we, 0);
                end else begin
                    chk("write_addr", bus.mem_addr, 16'h2004);
                    chk("write_we", bus.mem_we, 1);
                    chk("write_din", bus.mem_din, mem[src]);
                end
                if (bus.mem_we === 1'b1) wq.push_back(bus.mem_din);
                if (bus.mem_addr != 16'h2004 && bus.mem_addr[15:8] != pg) oob++;
            end
        end
    end
    task automatic idle_cycle(input logic [15:0] a, input logic [7:0] d, input logic we);
        @(posedge clk);
        #1;
        bus.cpu_addr = a;
        bus.cpu_din = d;
        bus.cpu_we = we;
    endtask
    // hp is the parity the HALT cycle must see
    task automatic trigger(input logic [7:0] p, input bit hp);
        @(posedge clk);
        #1;
        if (par == hp) begin
            @(posedge clk);
            #1;
        end
        bus.cpu_we = 1;
        bus.cpu_addr = 16'h4014;
        bus.cpu_din = p;
        @(posedge clk);
        #1;
        bus.cpu_we = 0;
        bus.cpu_addr = 16'h0000;
        bus.cpu_din = 8'h00;
    endtask
    task automatic run(input logic [7:0] p, input bit hp, input bit noise, input int rst_at, output int n);
        int wc;
        bit done, last_we;
        wq.delete();
        oob = 0;
        n = 0;
        wc = 0;
        done = 0;
        trigger(p, hp);
        for (int g = 0; g < 1000 && !done; g++) begin
            @(negedge clk);
            if (bus.cpu_rdy === 1'b1) done = 1;
            else begin
                n++;
                last_we = bus.mem_we;
                if (last_we) wc++;
                @(posedge clk);
                #1;
                if (reset) reset = 0;
                else if (rst_at != 0 && wc == rst_at - 1 && !last_we) reset = 1;
                if (noise && n >= 10 && n < 400) begin
                    bus.cpu_we = 1;
                    bus.cpu_addr = n[0] ? 16'h4014 : 16'h0300;
                    bus.cpu_din = 8'h33;
                end else begin
                    bus.cpu_we = 0;
                    bus.cpu_addr = 16'h0000;
                end
            end
        end
        if (!done) chk("stall_timeout", 0, 1);
    endtask
    initial begin
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i);
            mem[16'hFF00 + i] = 8'(i) ^ 8'h5A;
        end
        bus.cpu_addr = 16'h0000;
        bus.cpu_din = 8'h00;
        bus.cpu_we = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("reset_rdy", bus.cpu_rdy, 1);
        chk("reset_busy", bus.dma_busy, 0);
        idle_cycle(16'h0010, 8'hA5, 1);
        idle_cycle(16'h0010, 8'h00, 0);
        @(negedge clk);
        chk("pass_dout", bus.cpu_dout, 8'hA5);
        chk("pass_rdy", bus.cpu_rdy, 1);
        run(8'h02, 0, 0, 0, n);
        chk("even_stall", n, 513);
        chk("even_count", wq.size(), 256);
        for (int i = 0; i < 256 && i < wq.size(); i++) chk("even_byte", wq[i], i);
        chk("even_oob", oob, 0);
        run(8'h02, 1, 0, 0, n);
        chk("odd_stall", n, ALIGN_EN ? 514 : 513);
        chk("odd_count", wq.size(), 256);
        run(8'hFF, 0, 0, 0, n);
        chk("ff_stall", n, 513);
        chk("ff_count", wq.size(), 256);
        for (int i = 0; i < 256 && i < wq.size(); i++) chk("ff_byte", wq[i], i ^ 8'h5A);
        chk("ff_oob", oob, 0);
        run(8'h02, 0, 1, 0, n);
        chk("noise_stall", n, 513);
        chk("noise_count", wq.size(), 256);
        chk("noise_oob", oob, 0);
        chk("noise_mem", mem[16'h0300], 8'h00);
        run(8'h02, 0, 0, 100, n);
        chk("abort_busy", bus.dma_busy, 0);
        chk("abort_we", bus.mem_we, 0);
        repeat (5) @(negedge clk);
        chk("abort_count", wq.size(), 100);
        chk("abort_rdy", bus.cpu_rdy, 1);
        run(8'h02, 0, 0, 0, n);
        chk("rerun_stall", n, 513);
        chk("rerun_count", wq.size(), 256);
        for (int i = 0; i < 256 && i < wq.size(); i++) chk("rerun_byte", wq[i], i);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
